apb_master_wt: RTL



---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_timeout_cnt.sv | 27 ++
 rtl/apb_master_wt.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its bench.
// State encoding is fixed so waveforms and the downstream slave docs line up.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  // Register decoder downstream answers 0x00..0x07 and flags PSLVERR elsewhere.
  localparam logic [APB_ADDR_W-1:0] SLV_ADDR_LO = 8'h00;
  localparam logic [APB_ADDR_W-1:0] SLV_ADDR_HI = 8'h07;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-cycle watchdog: counts PREADY=0 cycles and flags the last allowed one.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expire = (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_master_wt.sv
// APB requester: valid/ready commands in, SETUP/ACCESS sequences out, one response pulse per transfer.
// Define APB_TIMEOUT_EN to add a watchdog that aborts ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_wt
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy
);

  // state  | meaning
  // IDLE   | no transfer in flight; cmd_ready high
  // SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
  // ACCESS | PSEL=1, PENABLE=1 until PREADY (or watchdog expiry)

  apb_state_t        state_q, state_d;
  logic              handshake, timeout_hit, done;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_wt: TIMEOUT_CYCLES must be within 2..255");
  end

`ifdef APB_TIMEOUT_EN
  logic expire;

  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (state_q == SETUP),
    .inc    (state_q == ACCESS && !PREADY),
    .expire (expire)
  );

  // A late PREADY on the expiry cycle still completes normally.
  assign timeout_hit = (state_q == ACCESS) && !PREADY && expire;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = PRESETn && (state_q == IDLE);
    busy      = (state_q != IDLE);
    handshake = cmd_valid && cmd_ready;
    done      = (state_q == ACCESS) && (PREADY || timeout_hit);
  end

  // APB and response outputs are all flops; select/enable follow the next state.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= done;
      if (handshake) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
      if (done) begin
        if (PREADY) begin
          rsp_err_q     <= PSLVERR;
          rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
          rsp_timeout_q <= 1'b0;
        end else begin
          rsp_err_q     <= 1'b1;
          rsp_rdata_q   <= '0;
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
